// File: rtl/rx_link_pkg.sv
// Shared types and framing constants for the two-wire button-code link receiver.
package rx_link_pkg;

  // Deframer states: waiting for a start bit, collecting data, then parity, then stop.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;
  localparam logic IDLE_LEVEL      = 1'b1;

  // Even parity over the data byte: the parity bit the transmitter sends.
  function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/link_sync.sv
// Multi-flop synchronizer for one asynchronous link wire; presets to the idle level.
module link_sync
  import rx_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw wire through the flop chain; reset to idle so no false edge appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {SYNC_STAGES{IDLE_LEVEL}};
    else        chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rx_frame_decoder.sv
// Receives start/8 data/even parity/stop frames clocked by link_clk and presents the code.
// Output pulses (code_valid, parity_err, frame_err) are single-cycle strobes with no
// back-pressure: downstream logic must consume them in the cycle they are high.
module rx_frame_decoder
  import rx_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       link_clk,
  input  logic       link_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output state_t     state_dbg
);

  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic           sync_clk, sync_data, sync_clk_d;
  logic           rise_q, bit_q;
  state_t         state, state_n;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic [7:0]     shreg, shreg_n;
  logic           par_bit, par_bit_n;
  logic [7:0]     code_n;
  logic           valid_n, perr_n, ferr_n;
  logic [TCW-1:0] tcnt, tcnt_n;

  link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(CLOCK_50), .rst_n(reset_n), .din(link_clk), .dout(sync_clk)
  );

  link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(CLOCK_50), .rst_n(reset_n), .din(link_data), .dout(sync_data)
  );

  // Registered rising-edge strobe; data is delayed by the same flop so it aligns with the strobe.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_clk_d <= IDLE_LEVEL;
      rise_q     <= 1'b0;
      bit_q      <= IDLE_LEVEL;
    end else begin
      sync_clk_d <= sync_clk;
      rise_q     <= sync_clk & ~sync_clk_d;
      bit_q      <= sync_data;
    end
  end

  // State and datapath registers for the deframer.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      tcnt       <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      code       <= code_n;
      code_valid <= valid_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      busy       <= (state_n != IDLE);
      tcnt       <= tcnt_n;
    end
  end

  // Next-state, shift, frame evaluation and inactivity timeout.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    code_n    = code;
    valid_n   = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    tcnt_n    = tcnt;
    if (rise_q) begin
      tcnt_n = '0;
      case (state)
        IDLE: begin
          if (bit_q == START_LEVEL) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shreg_n   = {bit_q, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'(FRAME_DATA_BITS - 1)) state_n = PARITY;
        end
        PARITY: begin
          par_bit_n = bit_q;
          state_n   = STOP;
        end
        STOP: begin
          state_n = IDLE;
          // A broken stop bit outranks a parity error: the whole frame is suspect.
          if (bit_q != STOP_LEVEL) begin
            ferr_n = 1'b1;
          end else if (par_bit != even_parity(shreg)) begin
            perr_n = 1'b1;
          end else begin
            code_n  = shreg;
            valid_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
        ferr_n  = 1'b1;
        state_n = IDLE;
        tcnt_n  = '0;
      end else begin
        tcnt_n = tcnt + TCW'(1);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed and randomized frames against a frame-level reference model and event scoreboard.
module tb_rx_frame_decoder;
  import rx_link_pkg::*;

  localparam int SYNC = 2;
  localparam int TMO  = 80;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       link_clk = 1'b1;
  logic       link_data = 1'b1;
  logic [7:0] code;
  logic       code_valid, parity_err, frame_err, busy;
  state_t     state_dbg;

  rx_frame_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .link_clk(link_clk), .link_data(link_data),
    .code(code), .code_valid(code_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: event word = {kind, busy, code, cycle}; kind 1=valid 2=parity 3=frame
  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  logic [7:0]  exp_code = 8'h00;
  int unsigned last_rise = 0;
  int          passes = 0;
  int          total = 0;

  function automatic logic [47:0] ev(input logic [6:0] kind, input logic b,
                                     input logic [7:0] c, input logic [31:0] cy);
    return {kind, b, c, cy};
  endfunction

  always @(negedge clk) begin
    if (code_valid) obs_q.push_back(ev(7'd1, busy, code, cyc));
    if (parity_err) obs_q.push_back(ev(7'd2, busy, code, cyc));
    if (frame_err)  obs_q.push_back(ev(7'd3, busy, code, cyc));
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver: one link bit, data changes on the falling edge, sampled on the rising edge
  task automatic link_bit(input logic b);
    @(posedge clk); #1;
    link_clk  = 1'b0;
    link_data = b;
    repeat (HALF) @(posedge clk);
    #1;
    link_clk  = 1'b1;
    last_rise = cyc;
    repeat (HALF - 1) @(posedge clk);
  endtask

  // reference model: outcome of a whole frame from its bits
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b);
    logic [10:0] bits;
    logic [31:0] at;
    bits = {stop_b, (^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) link_bit(bits[i]);
    at = 32'(last_rise + SYNC + 2);
    if (!stop_b)       exp_q.push_back(ev(7'd3, 1'b0, exp_code, at));
    else if (par_flip) exp_q.push_back(ev(7'd2, 1'b0, exp_code, at));
    else begin
      exp_code = d;
      exp_q.push_back(ev(7'd1, 1'b0, d, at));
    end
  endtask

  task automatic check_events(input string tag);
    @(negedge clk);
    chk({tag, "_count"}, 48'(obs_q.size()), 48'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_event"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
    chk({tag, "_code"}, 48'(code), 48'(exp_code));
    chk({tag, "_busy"}, 48'(busy), 48'(1'b0));
    chk({tag, "_state"}, 48'(state_dbg), 48'(IDLE));
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge clk);
    chk({tag, "_code"}, 48'(code), 48'(8'h00));
    chk({tag, "_pulses"}, 48'({code_valid, parity_err, frame_err}), 48'(3'b000));
    chk({tag, "_busy"}, 48'(busy), 48'(1'b0));
    chk({tag, "_state"}, 48'(state_dbg), 48'(IDLE));
  endtask

  initial begin
    logic [7:0]  d;
    int          k;
    int unsigned gap;

    // reset
    repeat (5) @(posedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    check_events("post_reset");

    // good frame, latency from stop-bit edge
    send_frame(8'hA5, 1'b0, 1'b1);
    check_events("a5");

    // bad parity keeps previous code
    send_frame(8'h01, 1'b1, 1'b1);
    check_events("bad_parity");

    // stop bit low
    send_frame(8'h3C, 1'b0, 1'b0);
    check_events("bad_stop");

    // timeout: start + 3 data bits, then link clock held low
    link_bit(1'b0);
    for (int i = 0; i < 3; i++) link_bit(1'($urandom_range(0, 1)));
    @(posedge clk); #1;
    link_clk  = 1'b0;
    link_data = 1'b1;
    exp_q.push_back(ev(7'd3, 1'b0, exp_code, 32'(last_rise + TMO + SYNC + 2)));
    repeat (TMO + 20) @(posedge clk);
    #1 link_clk = 1'b1;
    repeat (HALF - 1) @(posedge clk);
    check_events("timeout");
    send_frame(8'h7E, 1'b0, 1'b1);
    check_events("after_timeout");

    // reset during D4
    link_bit(1'b0);
    for (int i = 0; i < 4; i++) link_bit(1'($urandom_range(0, 1)));
    @(posedge clk); #1;
    link_clk  = 1'b0;
    link_data = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_code = 8'h00;
    repeat (10) @(posedge clk);
    check_outputs_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 link_clk = 1'b1;
    repeat (HALF - 1) @(posedge clk);
    for (int i = 0; i < 5; i++) link_bit(1'b1);
    check_events("reset_tail");
    send_frame(8'h42, 1'b0, 1'b1);
    check_events("after_reset");

    // back-to-back frames, no idle bit
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'hEE, 1'b0, 1'b1);
    @(negedge clk);
    if (obs_q.size() >= 2) begin
      gap = obs_q[1][31:0] - obs_q[0][31:0];
      chk("b2b_spacing", 48'(gap), 48'(11 * 2 * HALF));
    end
    check_events("b2b");

    // randomized frames with random idle gaps and corruption
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 2)) link_bit(1'b1);
      d = 8'($urandom_range(0, 255));
      k = int'($urandom_range(0, 3));
      if (k == 3) send_frame(d, 1'($urandom_range(0, 1)), 1'b0);
      else        send_frame(d, (k == 2), 1'b1);
      check_events("random");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
